pipelined_cla_adder: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor; successor to the 16-bit single-cycle CLA.
//  4-bit CLA groups with group P/G lookahead; BLOCKS_PER_STAGE groups resolved per pipeline stage.

---
 rtl/pipelined_cla_adder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
//   Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready
//   streaming on both sides. Each pipeline stage resolves BLOCKS_PER_STAGE
//   4-bit CLA groups (bit-level lookahead inside a group, group P/G lookahead
//   across the groups of the stage). The carry between stages is registered,
//   lower sum bits travel down the pipe with the beat, and only the operand
//   bits still to be consumed are carried forward.
//
//   Parameters
//     WIDTH            operand width, multiple of 4*BLOCKS_PER_STAGE, 8..64
//     BLOCKS_PER_STAGE 4-bit groups per stage; STAGES = WIDTH/(4*BPS)
//
//   Ports
//     Clk        rising-edge clock
//     Reset      synchronous, active-high; clears every valid bit and S/cout/ovf
//     in_valid   operand beat valid          in_ready  beat accepted this cycle
//     A, B       operands                    cin       carry-in (ignored if sub)
//     sub        1: S = A - B (B inverted, carry-in forced to 1)
//     out_valid  result beat valid           out_ready downstream accepts result
//     S          sum / difference            cout      carry out of MSB
//     ovf        signed overflow
//
//   Latency is STAGES cycles, throughput one beat per cycle. The whole pipe
//   stalls together whenever the output holds a beat that is not taken.
//
//   Optional feature macro: CLA_SATURATE_EN -- on signed overflow the result
//   is clamped to the signed max/min in the final stage.
// -----------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH            = 32,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int BPS    = BLOCKS_PER_STAGE;
    localparam int SW     = 4 * BPS;
    localparam int STAGES = WIDTH / SW;

    // Bit carries c1..c3 of a 4-bit group (c0 passes straight through).
    function automatic logic [3:0] cla4_carry(input logic [2:0] p,
                                              input logic [2:0] g,
                                              input logic       c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    // Group generate of a 4-bit group (p[0] does not take part).
    function automatic logic grp_gen(input logic [3:1] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Global stall: the pipe moves only when the output slot is free or taken.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Inter-stage buses; index k is the input of stage k.
    logic [STAGES:0]  v_pipe;
    logic [STAGES:0]  c_pipe;
    logic [WIDTH-1:0] s_pipe [STAGES+1];
    logic [WIDTH-1:0] a_pipe [STAGES];
    logic [WIDTH-1:0] b_pipe [STAGES];

    assign v_pipe[0] = in_valid;
    assign c_pipe[0] = sub | cin;
    assign s_pipe[0] = '0;
    assign a_pipe[0] = A;
    assign b_pipe[0] = B ^ {WIDTH{sub}};

    logic ovf_d;
    logic ovf_q;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [SW-1:0]    a_sl, b_sl, p, g, sl;
            logic [BPS-1:0]   gp, gg;
            logic [BPS:0]     gc;
            logic             c_acc, prod;
            logic [3:0]       bc;
            logic [WIDTH-1:0] s_next, s_res, s_d, s_q;
            logic             valid_d, valid_q, carry_d, carry_q;

            always_comb begin
                a_sl  = a_pipe[gi][gi*SW +: SW];
                b_sl  = b_pipe[gi][gi*SW +: SW];
                p     = a_sl ^ b_sl;
                g     = a_sl & b_sl;
                gp    = '0;
                gg    = '0;
                gc    = '0;
                c_acc = 1'b0;
                prod  = 1'b0;
                bc    = '0;
                sl    = '0;
                for (int j = 0; j < BPS; j++) begin
                    gp[j] = &p[4*j +: 4];
                    gg[j] = grp_gen(p[4*j+1 +: 3], g[4*j +: 4]);
                end
                // Group lookahead: each group carry is a flat sum of products
                // of the lower groups' G/P terms and the stage carry-in.
                gc[0] = c_pipe[gi];
                for (int j = 0; j < BPS; j++) begin
                    c_acc = gg[j];
                    prod  = gp[j];
                    for (int i = j - 1; i >= 0; i--) begin
                        c_acc = c_acc | (prod & gg[i]);
                        prod  = prod & gp[i];
                    end
                    gc[j+1] = c_acc | (prod & c_pipe[gi]);
                end
                for (int j = 0; j < BPS; j++) begin
                    bc           = cla4_carry(p[4*j +: 3], g[4*j +: 3], gc[j]);
                    sl[4*j +: 4] = p[4*j +: 4] ^ bc;
                end
                s_next = s_pipe[gi];
                s_next[gi*SW +: SW] = sl;
            end

            // Bubbles clear the valid bit but leave the data registers alone.
            always_comb begin
                valid_d = valid_q;
                carry_d = carry_q;
                s_d     = s_q;
                if (advance) begin
                    valid_d = v_pipe[gi];
                    if (v_pipe[gi]) begin
                        carry_d = gc[BPS];
                        s_d     = s_res;
                    end
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    s_q     <= '0;
                end else begin
                    valid_q <= valid_d;
                    carry_q <= carry_d;
                    s_q     <= s_d;
                end
            end

            assign v_pipe[gi+1] = valid_q;
            assign c_pipe[gi+1] = carry_q;
            assign s_pipe[gi+1] = s_q;

            if (gi < STAGES - 1) begin : g_fwd
                // Consumed operand bits are forced to zero so those flops
                // are constant and drop out.
                logic [WIDTH-1:0] a_d, a_q, b_d, b_q;

                always_comb begin
                    a_d = a_q;
                    b_d = b_q;
                    if (advance && v_pipe[gi]) begin
                        a_d = a_pipe[gi];
                        b_d = b_pipe[gi];
                        a_d[(gi+1)*SW-1:0] = '0;
                        b_d[(gi+1)*SW-1:0] = '0;
                    end
                end

                always_ff @(posedge Clk) begin
                    if (Reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end

                assign a_pipe[gi+1] = a_q;
                assign b_pipe[gi+1] = b_q;
                assign s_res        = s_next;
            end else begin : g_fin
                // Overflow: operands (B already conditionally inverted) share
                // a sign and the result sign differs from it.
                logic ovf_w;
                assign ovf_w = ~(a_pipe[gi][WIDTH-1] ^ b_pipe[gi][WIDTH-1])
                             & (s_next[WIDTH-1] ^ a_pipe[gi][WIDTH-1]);
`ifdef CLA_SATURATE_EN
                localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
                localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
                assign s_res = ovf_w ? (a_pipe[gi][WIDTH-1] ? SMIN : SMAX) : s_next;
`else
                assign s_res = s_next;
`endif
                always_comb begin
                    ovf_d = ovf_q;
                    if (advance && v_pipe[gi]) begin
                        ovf_d = ovf_w;
                    end
                end

                always_ff @(posedge Clk) begin
                    if (Reset) begin
                        ovf_q <= 1'b0;
                    end else begin
                        ovf_q <= ovf_d;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = v_pipe[STAGES];
    assign S         = s_pipe[STAGES];
    assign cout      = c_pipe[STAGES];
    assign ovf       = ovf_q;

endmodule
